grid_plotter: RTL
=================

Name: grid_plotter

Overview:
- Parametrised successor to the game's cell-cursor/colour translator.
- Tracks a row/column cursor over a ROWS x COLS answer grid, advanced by guess-result strokes.
- Rasterises the selected cell into per-pixel X/Y/colour/plot strobes for the VGA adapter, in filled, outline or erase mode.
- Sits between the game FSM (step/correct/selection) and the VGA adapter plot port, in the single system clock domain.

Parameters:
- ROWS, 5: cells per column; cursor row range 0..ROWS-1; ROWS <= 32.
- COLS, 6: columns on the board; COLS <= 32.
- X_ORIGIN, 20: pixel X of cell (row 0, col 0).
- Y_ORIGIN, 30: pixel Y of cell (row 0, col 0).
- X_PITCH, 10: pixel X step per column.
- Y_PITCH, 4: pixel Y step per row.
- CELL_W, 8: cell width in pixels; CELL_W >= 2.
- CELL_H, 3: cell height in pixels; CELL_H >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle strobe: one guess result is available.
- correct  in  1  result qualifier, sampled with step.
- selection  in  2  draw mode, sampled with step.
- x  out  8  pixel X.
- y  out  8  pixel Y.
- colour  out  3  pixel colour, RGB.
- plot  out  1  write strobe for the current x/y/colour.
- busy  out  1  high while a cell is being rasterised.
- done  out  1  one-cycle pulse when rasterisation ends.
- row  out  5  cursor row.
- column  out  5  cursor column.
- board_full  out  1  high once the cursor has left the last column.

Behaviour:
- Reset (async, reset=0): state IDLE; row=0, column=0; x=0, y=0, colour=0; plot=0, busy=0, done=0, board_full=0. Reset mid-draw aborts immediately; no further plots.
- States are IDLE, DRAW and DONE.
- Step acceptance:
  - step is accepted only in IDLE with board_full=0.
  - Steps in DRAW, DONE or while board_full=1 are dropped silently, with no cursor change.
- On an accepted step at edge k:
  - Latch cell (row, column) as currently held and the selection mode; enter DRAW.
  - Cursor update in the same edge:
    - correct=1 and row==ROWS-1: row=0, column+1.
    - correct=1 otherwise: row+1.
    - correct=0: row=0.
  - If correct=1, row==ROWS-1 and column==COLS-1: column stays COLS-1, row=0, board_full=1 (sticky until reset).
- Selection modes:
  - 00: colour 100, filled.
  - 01: colour 111, filled.
  - 11: colour 111, outline.
  - 10: colour 000, filled (erase).
  - No mode holds a previous value.
- DRAW:
  - Visits dy=0..CELL_H-1 (outer) and dx=0..CELL_W-1 (inner), one pixel per cycle. The first pixel is presented in the cycle after edge k.
  - x = X_ORIGIN + col*X_PITCH + dx; y = Y_ORIGIN + row*Y_PITCH + dy; truncated to 8 bits.
  - Filled mode: plot=1 on every visited pixel.
  - Outline mode: plot=1 only when dx is 0 or CELL_W-1, or dy is 0 or CELL_H-1. Interior pixels are still visited with plot=0.
  - DRAW lasts exactly CELL_W*CELL_H cycles, then moves to DONE.
- DONE: one cycle; done=1, plot=0, busy=1. Then IDLE.
- busy=1 in DRAW and DONE, so a step on the done cycle is dropped.
- Outputs x/y/colour/plot are registered; x/y/colour hold their last values in IDLE, with plot=0.

Optional Feature:
- Macro: GRID_PLOTTER_MISS_ERASE_EN.
- Defined: an accepted step with correct=0 ignores selection and erases cells rows 0..r of the latched column c, in order. Here r and c are the latched (pre-update) cursor values.
  - Each cell is rasterised in erase mode (colour 000, filled), back-to-back with no gap.
  - Total DRAW time is (r+1)*CELL_W*CELL_H cycles, followed by one DONE cycle.
  - The cursor update is unchanged.
- Undefined: a correct=0 step draws the latched cell with the latched selection, like any other step.

Test Plan:
- Fill: after reset, step with correct=1, sel=00. Expect 24 plot cycles, x 20..27 and y 30..32 in row-major order, colour=100; then done for 1 cycle; row=1, column=0.
- Outline: from row=1, step with correct=1, sel=11. Expect 24 visited pixels at y 34..36 with exactly 18 plot=1, where interior dx 1..6 at y=35 has plot=0; colour=111.
- Column wrap: 5 correct steps, then a 6th with sel=01. Expect the 6th cell drawn at x 30..37, y 30..32; row=1, column=1 afterwards.
- Busy/drop: step during DRAW and again on the done cycle. Expect no cursor change, no extra plots, and exactly one done pulse.
- Board full: 30 correct steps. Expect board_full=1 after the 30th, column=5, row=0; a 31st step gives busy=0 and no plot.
- Reset mid-draw: assert reset at pixel 10. Expect plot=0 and busy=0 asynchronously, and row/column/board_full=0.
- Miss erase (macro on): from row=3, column=2, step with correct=0. Expect 96 plot cycles of colour 000 at x 40..47, y 30..44, then row=0.

Source files
------------

// File: rtl/grid_plotter.sv
// grid_plotter: cell cursor over a ROWS x COLS answer grid plus a cell
// rasteriser that emits per-pixel x/y/colour/plot strobes for a VGA adapter.
// Optional feature macro: GRID_PLOTTER_MISS_ERASE_EN. When it is defined, a
// miss (correct=0) erases rows 0..r of the current column in one busy period.
module grid_plotter #(
    parameter int ROWS     = 5,
    parameter int COLS     = 6,
    parameter int X_ORIGIN = 20,
    parameter int Y_ORIGIN = 30,
    parameter int X_PITCH  = 10,
    parameter int Y_PITCH  = 4,
    parameter int CELL_W   = 8,
    parameter int CELL_H   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    input  logic       correct,
    input  logic [1:0] selection,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [4:0] row,
    output logic [4:0] column,
    output logic       board_full
);

    localparam int DXW = $clog2(CELL_W);
    localparam int DYW = $clog2(CELL_H);

    localparam logic [1:0] MODE_ERASE   = 2'b10;
    localparam logic [1:0] MODE_OUTLINE = 2'b11;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t state, state_next;

    // Cell currently being rasterised and the pixel offset within it
    logic [4:0]     cell_row, cell_col, end_row;
    logic [1:0]     mode;
    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;

    // Next pixel to present, produced by the control block
    logic           pix_load;
    logic [4:0]     pix_row, pix_col;
    logic [1:0]     pix_mode;
    logic [DXW-1:0] pix_dx;
    logic [DYW-1:0] pix_dy;

    logic           accept, last_px, last_cell;
    logic [1:0]     accept_mode;
    logic [4:0]     start_row;
    logic [7:0]     px_x, px_y;
    logic [2:0]     px_colour;
    logic           px_plot, px_edge;

    assign accept    = step && (state == IDLE) && !board_full;
    assign last_px   = (dx == DXW'(CELL_W - 1)) && (dy == DYW'(CELL_H - 1));
    assign last_cell = (cell_row == end_row);

`ifdef GRID_PLOTTER_MISS_ERASE_EN
    // A miss wipes the column from the top down to the cursor row
    assign accept_mode = correct ? selection : MODE_ERASE;
    assign start_row   = correct ? row : 5'd0;
`else
    assign accept_mode = selection;
    assign start_row   = row;
`endif

    // Pixel coordinates wrap modulo 256, matching an 8-bit VGA port
    assign px_x = 8'(X_ORIGIN) + 8'(pix_col) * 8'(X_PITCH) + 8'(pix_dx);
    assign px_y = 8'(Y_ORIGIN) + 8'(pix_row) * 8'(Y_PITCH) + 8'(pix_dy);
    assign px_edge = (pix_dx == '0) || (pix_dx == DXW'(CELL_W - 1)) ||
                     (pix_dy == '0) || (pix_dy == DYW'(CELL_H - 1));
    assign px_plot = (pix_mode != MODE_OUTLINE) || px_edge;

    // Colour decode of the latched draw mode
    always_comb begin
        unique case (pix_mode)
            2'b00:   px_colour = 3'b100;
            2'b01:   px_colour = 3'b111;
            2'b11:   px_colour = 3'b111;
            default: px_colour = 3'b000;
        endcase
    end

    // Next-state, status outputs and next-pixel selection
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pix_load   = 1'b0;
        pix_row    = cell_row;
        pix_col    = cell_col;
        pix_mode   = mode;
        pix_dx     = dx;
        pix_dy     = dy;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DRAW;
                    pix_load   = 1'b1;
                    pix_row    = start_row;
                    pix_col    = column;
                    pix_mode   = accept_mode;
                    pix_dx     = '0;
                    pix_dy     = '0;
                end
            end
            DRAW: begin
                busy = 1'b1;
                if (last_px) begin
                    if (last_cell) begin
                        state_next = DONE;
                    end else begin
                        pix_load = 1'b1;
                        pix_row  = cell_row + 5'd1;
                        pix_dx   = '0;
                        pix_dy   = '0;
                    end
                end else begin
                    pix_load = 1'b1;
                    if (dx == DXW'(CELL_W - 1)) begin
                        pix_dx = '0;
                        pix_dy = dy + 1'b1;
                    end else begin
                        pix_dx = dx + 1'b1;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Pixel output registers and rasteriser position
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cell_row <= '0;
            cell_col <= '0;
            mode     <= '0;
            dx       <= '0;
            dy       <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
        end else if (pix_load) begin
            cell_row <= pix_row;
            cell_col <= pix_col;
            mode     <= pix_mode;
            dx       <= pix_dx;
            dy       <= pix_dy;
            x        <= px_x;
            y        <= px_y;
            colour   <= px_colour;
            plot     <= px_plot;
        end else begin
            plot     <= 1'b0;
        end
    end

    // Cursor advance on accepted steps; board_full is sticky until reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row        <= '0;
            column     <= '0;
            end_row    <= '0;
            board_full <= 1'b0;
        end else if (accept) begin
            end_row <= row;
            if (correct) begin
                if (row == 5'(ROWS - 1)) begin
                    row <= '0;
                    if (column == 5'(COLS - 1)) board_full <= 1'b1;
                    else                        column     <= column + 5'd1;
                end else begin
                    row <= row + 5'd1;
                end
            end else begin
                row <= '0;
            end
        end
    end

endmodule
